// File: rtl/multicyc_ctrl_pkg.sv
// Shared types and helpers for the EX-stage multi-cycle HI/LO sequencer.
// MULTICYC_ACCUM_EN adds the ACC state and makes MADD/MADDU/MSUB/MSUBU multi-cycle.
package cpu_defs;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MTHI, OP_MTLO,
    OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } oper_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_DONE
`ifdef MULTICYC_ACCUM_EN
    , ST_ACC
`endif
  } multicyc_state_t;

  localparam int MUL_CYC_DEFAULT = 2;
  localparam int DIV_ITER        = 32;

  function automatic logic is_accum_op(oper_t op);
    return op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU;
  endfunction

  function automatic logic is_div_op(oper_t op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction

  function automatic logic is_signed_op(oper_t op);
    return op == OP_MULT || op == OP_DIV || op == OP_MADD || op == OP_MSUB;
  endfunction

  function automatic logic is_multicyc_op(oper_t op);
    logic mc;
    mc = op == OP_MULT || op == OP_MULTU || is_div_op(op);
`ifdef MULTICYC_ACCUM_EN
    mc = mc || is_accum_op(op);
`endif
    return mc;
  endfunction

endpackage

// File: rtl/multicyc_ctrl_div_iter.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; the sequencer owns the remainder and quotient registers.
module div_iter (
  input  logic [32:0] rem_in,
  input  logic [31:0] divisor,
  input  logic [31:0] quo_in,
  output logic [32:0] rem_out,
  output logic [31:0] quo_out
);
  logic [33:0] shifted;
  logic        fits;

  assign shifted = {rem_in, quo_in[31]};
  assign fits    = shifted >= {2'b00, divisor};
  assign rem_out = fits ? 33'(shifted - {2'b00, divisor}) : shifted[32:0];
  assign quo_out = {quo_in[30:0], fits};
endmodule

// File: rtl/multicyc_ctrl.sv
// EX-stage HI/LO sequencer: fixed-latency MULT, 32-step DIV, single HI/LO write, MTHI/MTLO pass-through.
// Define MULTICYC_ACCUM_EN to add MADD/MADDU/MSUB/MSUBU through an extra ACC state.
module multicyc_ctrl
  import cpu_defs::*;
#(
  parameter int MUL_CYC = MUL_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  oper_t       req_op,
  input  logic [31:0] req_reg0,
  input  logic [31:0] req_reg1,
  input  logic [63:0] req_hilo,
  input  logic        accept,
  output logic        resp_ready,
  output logic        resp_hilo_we,
  output logic [63:0] resp_hilo,
  output logic        busy
);
  multicyc_state_t    state;
  logic [4:0]         cnt;
  logic [63:0]        res;
  logic [32:0]        rem;
  logic [31:0]        quo;
  logic [31:0]        dsr;
  logic               neg_q;
  logic               neg_r;
  logic [32:0]        rem_nx;
  logic [31:0]        quo_nx;
  logic               sgn;
  logic               launch;
  logic [31:0]        abs0;
  logic [31:0]        abs1;
  logic signed [63:0] ma;
  logic signed [63:0] mb;
  logic signed [63:0] prod;
`ifdef MULTICYC_ACCUM_EN
  logic [63:0]        hilo_lat;
  logic               acc_op;
  logic               acc_sub;
`endif

  assign sgn    = is_signed_op(req_op);
  assign launch = req_valid && !flush && is_multicyc_op(req_op);
  assign abs0   = (sgn && req_reg0[31]) ? -req_reg0 : req_reg0;
  assign abs1   = (sgn && req_reg1[31]) ? -req_reg1 : req_reg1;
  assign ma     = sgn ? {{32{req_reg0[31]}}, req_reg0} : {32'd0, req_reg0};
  assign mb     = sgn ? {{32{req_reg1[31]}}, req_reg1} : {32'd0, req_reg1};
  assign prod   = ma * mb;

  div_iter u_div_iter (
    .rem_in  (rem),
    .divisor (dsr),
    .quo_in  (quo),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
      res   <= '0;
      rem   <= '0;
      quo   <= '0;
      dsr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`ifdef MULTICYC_ACCUM_EN
      hilo_lat <= '0;
      acc_op   <= 1'b0;
      acc_sub  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            if (is_div_op(req_op)) begin
              // Pre-load the divide-by-zero answer; overwritten at the end when the divisor is non-zero.
              res   <= {req_reg0, 32'hFFFF_FFFF};
              rem   <= '0;
              quo   <= abs0;
              dsr   <= abs1;
              neg_q <= sgn && (req_reg0[31] ^ req_reg1[31]);
              neg_r <= sgn && req_reg0[31];
              cnt   <= 5'(DIV_ITER - 1);
              state <= ST_DIV;
            end else begin
              res   <= prod;
              cnt   <= 5'(MUL_CYC - 1);
              state <= ST_MUL;
`ifdef MULTICYC_ACCUM_EN
              hilo_lat <= req_hilo;
              acc_op   <= is_accum_op(req_op);
              acc_sub  <= req_op == OP_MSUB || req_op == OP_MSUBU;
`endif
            end
          end
        end
        ST_MUL: begin
          if (cnt == 5'd0) begin
`ifdef MULTICYC_ACCUM_EN
            state <= acc_op ? ST_ACC : ST_DONE;
`else
            state <= ST_DONE;
`endif
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state <= ST_DONE;
            if (dsr != 32'd0)
              res <= {neg_r ? -rem_nx[31:0] : rem_nx[31:0], neg_q ? -quo_nx : quo_nx};
          end
        end
`ifdef MULTICYC_ACCUM_EN
        ST_ACC: begin
          res   <= acc_sub ? hilo_lat - res : hilo_lat + res;
          state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (accept)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    resp_ready   = 1'b1;
    resp_hilo_we = 1'b0;
    resp_hilo    = '0;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          resp_ready = 1'b0;
        end else if (req_op == OP_MTHI) begin
          resp_hilo    = {req_reg0, req_hilo[31:0]};
          resp_hilo_we = req_valid && !flush;
        end else if (req_op == OP_MTLO) begin
          resp_hilo    = {req_hilo[63:32], req_reg0};
          resp_hilo_we = req_valid && !flush;
        end
      end
      ST_DONE: begin
        resp_hilo    = res;
        resp_hilo_we = !flush;
      end
      default: resp_ready = 1'b0;
    endcase
  end

  assign busy = state != ST_IDLE;
endmodule

// File: tb/tb_multicyc_ctrl.sv
// Self-checking bench for multicyc_ctrl: directed literal cases plus randomized traffic
// compared each cycle against a transaction-level latency/result model.
module tb_multicyc_ctrl;
  import cpu_defs::*;

  localparam int MUL_CYC = 2;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, accept;
  oper_t       req_op;
  logic [31:0] req_reg0, req_reg1;
  logic [63:0] req_hilo;
  logic        resp_ready, resp_hilo_we, busy;
  logic [63:0] resp_hilo;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Model: 0 idle, 1 operation running, 2 result presented.
  int          m_mode = 0;
  int          m_left = 0;
  logic [63:0] m_res  = '0;

  multicyc_ctrl #(.MUL_CYC(MUL_CYC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_op(req_op),
    .req_reg0(req_reg0), .req_reg1(req_reg1), .req_hilo(req_hilo), .accept(accept),
    .resp_ready(resp_ready), .resp_hilo_we(resp_hilo_we), .resp_hilo(resp_hilo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_mc(oper_t op);
    bit r;
    r = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`ifdef MULTICYC_ACCUM_EN
    r = r || (op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
`endif
    return r;
  endfunction

  function automatic int ref_lat(oper_t op);
    if (op inside {OP_DIV, OP_DIVU}) return 33;
    if (op inside {OP_MULT, OP_MULTU}) return MUL_CYC + 1;
    return MUL_CYC + 2;
  endfunction

  function automatic logic [63:0] ref_result(oper_t op, logic [31:0] a, logic [31:0] b, logic [63:0] h);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic [31:0] ua, ub, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (op inside {OP_MULT, OP_MADD, OP_MSUB}) p = sa * sb;
    else p = {32'd0, a} * {32'd0, b};
    case (op)
      OP_MULT, OP_MULTU: return p;
      OP_MADD, OP_MADDU: return h + p;
      OP_MSUB, OP_MSUBU: return h - p;
      OP_DIVU: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        ua = a[31] ? -a : a;
        ub = b[31] ? -b : b;
        q = ua / ub;
        r = ua % ub;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  always @(negedge clk) begin : compare
    logic [63:0] eh;
    logic er, ew, eb, go;
    if (chk_on) begin
      eh = '0; er = 1'b1; ew = 1'b0; eb = 1'b0;
      go = req_valid && !flush && ref_mc(req_op);
      case (m_mode)
        0: begin
          er = !go;
          if (!go && req_op == OP_MTHI) begin
            eh = {req_reg0, req_hilo[31:0]};
            ew = req_valid && !flush;
          end else if (!go && req_op == OP_MTLO) begin
            eh = {req_hilo[63:32], req_reg0};
            ew = req_valid && !flush;
          end
        end
        1: begin er = 1'b0; eb = 1'b1; end
        default: begin eh = m_res; ew = !flush; eb = 1'b1; end
      endcase
      chk("busy", 64'(busy), 64'(eb));
      chk("resp_ready", 64'(resp_ready), 64'(er));
      chk("resp_hilo_we", 64'(resp_hilo_we), 64'(ew));
      if (ew) chk("resp_hilo", resp_hilo, eh);
      if (rst) m_mode = 0;
      else case (m_mode)
        0: if (go) begin
          m_mode = 1;
          m_left = ref_lat(req_op) - 1;
          m_res  = ref_result(req_op, req_reg0, req_reg1, req_hilo);
        end
        1: if (flush) m_mode = 0;
           else begin
             m_left--;
             if (m_left == 0) m_mode = 2;
           end
        default: if (flush || accept) m_mode = 0;
      endcase
    end
  end

  task automatic idle_inputs();
    req_valid = 1'b0; req_op = OP_NOP; flush = 1'b0; accept = 1'b0;
    req_reg0 = '0; req_reg1 = '0; req_hilo = '0;
  endtask

  // Issue one op held stable until done; check latency, result and optional held write.
  task automatic run_op(input string name, input oper_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h, input logic [63:0] exp, input int lat, input int hold);
    bit seen;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_reg0 = a; req_reg1 = b; req_hilo = h;
    flush = 1'b0; accept = (hold == 0);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (resp_ready) begin
        seen = 1'b1;
        chk({name, "_latency"}, 64'(k), 64'(lat));
        chk({name, "_result"}, resp_hilo, exp);
        chk({name, "_we"}, 64'(resp_hilo_we), 64'd1);
      end
    end
    if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == hold - 1) accept = 1'b1;
      @(negedge clk);
      chk({name, "_held_we"}, 64'(resp_hilo_we), 64'd1);
      chk({name, "_held_result"}, resp_hilo, exp);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 20));
      2: return 32'h8000_0000;
      3: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset_ready", 64'(resp_ready), 64'd1);
    chk("reset_we", 64'(resp_hilo_we), 64'd0);
    chk("reset_hilo", resp_hilo, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, '0, 64'hFFFF_FFFF_FFFF_FFFA, 3, 0);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, '0, 64'h0000_0002_0000_000E, 33, 0);
    run_op("div_neg", OP_DIV, -32'd7, 32'd2, '0, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
    run_op("div_zero", OP_DIV, 32'd5, 32'd0, '0, 64'h0000_0005_FFFF_FFFF, 33, 0);
    run_op("multu_hold", OP_MULTU, 32'd7, 32'd6, '0, 64'd42, 3, 3);

    // Flush a divide mid-flight.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_DIV; req_reg0 = 32'd1000; req_reg1 = 32'd3;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    flush = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    run_op("multu_after_flush", OP_MULTU, 32'd3, 32'd4, '0, 64'd12, 3, 0);

    // MTLO pass-through in the same cycle.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_MTLO; req_reg0 = 32'h1234; req_hilo = 64'hAAAA_0000_BBBB_0000;
    @(negedge clk);
    chk("mtlo_ready", 64'(resp_ready), 64'd1);
    chk("mtlo_we", 64'(resp_hilo_we), 64'd1);
    chk("mtlo_hilo", resp_hilo, 64'hAAAA_0000_0000_1234);
    @(posedge clk); #1;
    idle_inputs();

    // Reset in the middle of a divide.
    req_valid = 1'b1; req_op = OP_DIVU; req_reg0 = 32'd77; req_reg1 = 32'd5;
    repeat (5) begin @(posedge clk); #1; end
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ready", 64'(resp_ready), 64'd1);
    chk("rst_mid_we", 64'(resp_hilo_we), 64'd0);
    chk("rst_mid_hilo", resp_hilo, 64'd0);

`ifdef MULTICYC_ACCUM_EN
    run_op("msubu", OP_MSUBU, 32'd2, 32'd3, 64'd10, 64'd4, MUL_CYC + 2, 0);
    run_op("madd_wrap", OP_MADD, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, MUL_CYC + 2, 0);
`else
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_MADD; req_reg0 = 32'd2; req_reg1 = 32'd3; req_hilo = 64'd10;
    @(negedge clk);
    chk("madd_off_ready", 64'(resp_ready), 64'd1);
    chk("madd_off_we", 64'(resp_hilo_we), 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("madd_off_busy", 64'(busy), 64'd0);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 63) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_op    = oper_t'($urandom_range(0, 13));
      req_reg0  = rnd_val();
      req_reg1  = rnd_val();
      req_hilo  = {$urandom, $urandom};
      accept    = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
